// File: rtl/abs_pkg.sv
// Shared definitions for the multi-channel ABS controller.
// Holds the per-wheel state encoding, the default parameter values and the
// helper functions used to size the timer and to build the reference speed.
package abs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    RELEASE = 2'd2,
    LOCK    = 2'd3
  } wheel_state_t;

  localparam int DEF_N_WHEELS      = 4;
  localparam int DEF_SPD_W         = 8;
  localparam int DEF_SLIP_MARGIN   = 10;
  localparam int DEF_MIN_ABS_SPEED = 15;
  localparam int DEF_RELEASE_CYC   = 4;
  localparam int DEF_APPLY_MIN_CYC = 6;

  // Unsigned maximum; applied pairwise to reduce all wheel speeds to ref_speed.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The timer must hold the larger of the two reload values.
  function automatic int unsigned tmr_width(input int unsigned rel_cyc,
                                            input int unsigned app_cyc);
    return $clog2(max_u(rel_cyc, app_cyc) + 1);
  endfunction

endpackage

// File: rtl/abs_multi_channel_if.sv
// Pedal/obstacle/sensor inputs and per-wheel actuator outputs of the ABS block.
//   master : drives brake_pedal, object_detected, abs_enable, wheel_speed;
//            observes brake_cmd, abs_active, ref_speed
//   slave  : the ABS controller side (mirror of master)
interface abs_multi_channel_if
  import abs_pkg::*;
#(
  parameter int N_WHEELS = DEF_N_WHEELS,
  parameter int SPD_W    = DEF_SPD_W
);

  logic                      brake_pedal;
  logic                      object_detected;
  logic                      abs_enable;
  logic [N_WHEELS*SPD_W-1:0] wheel_speed;
  logic [N_WHEELS-1:0]       brake_cmd;
  logic                      abs_active;
  logic [SPD_W-1:0]          ref_speed;

  modport master (
    output brake_pedal, object_detected, abs_enable, wheel_speed,
    input  brake_cmd, abs_active, ref_speed
  );

  modport slave (
    input  brake_pedal, object_detected, abs_enable, wheel_speed,
    output brake_cmd, abs_active, ref_speed
  );

endinterface

// File: rtl/abs_wheel_channel.sv
// One wheel's brake modulation FSM with its release/dwell down-counter.
//   clk, rst         : clock, asynchronous active-high reset
//   brake_pedal      : driver brake request
//   object_detected  : forces LOCK (full brake), highest priority
//   slip             : this wheel is slipping and ABS modulation is allowed
//   brake_cmd        : 1 = actuator applied (APPLY or LOCK)
//   releasing        : 1 while the channel is in RELEASE
module abs_wheel_channel
  import abs_pkg::*;
#(
  parameter int RELEASE_CYC   = DEF_RELEASE_CYC,
  parameter int APPLY_MIN_CYC = DEF_APPLY_MIN_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic brake_pedal,
  input  logic object_detected,
  input  logic slip,
  output logic brake_cmd,
  output logic releasing
);

  localparam int TMR_W = tmr_width(RELEASE_CYC, APPLY_MIN_CYC);

  wheel_state_t     state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // NOTE: defaults are assigned first so that every path drives state_d and
  // tmr_d; a missing assignment in a branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (object_detected) begin
      state_d = LOCK;
      tmr_d   = '0;
    end else if (!brake_pedal) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, LOCK: begin
          // First apply after idle or lock has no dwell: slip acts at once.
          state_d = APPLY;
          tmr_d   = '0;
        end
        APPLY: begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
          end else if (slip) begin
            state_d = RELEASE;
            tmr_d   = TMR_W'(RELEASE_CYC - 1);
          end
        end
        RELEASE: begin
          if (tmr_q == '0) begin
            state_d = APPLY;
            tmr_d   = TMR_W'(APPLY_MIN_CYC - 1);
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  assign brake_cmd = (state_q == APPLY) || (state_q == LOCK);
  assign releasing = (state_q == RELEASE);

endmodule

// File: rtl/abs_multi_channel.sv
// Multi-wheel anti-lock braking controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of abs_multi_channel_if
//              (pedal/obstacle/enable/wheel speeds in; brake_cmd,
//               abs_active, ref_speed out)
// ref_speed is the combinational maximum of all wheel speeds; each wheel has
// an independent channel that pulses its brake when it lags ref_speed.
module abs_multi_channel
  import abs_pkg::*;
#(
  parameter int N_WHEELS      = DEF_N_WHEELS,
  parameter int SPD_W         = DEF_SPD_W,
  parameter int SLIP_MARGIN   = DEF_SLIP_MARGIN,
  parameter int MIN_ABS_SPEED = DEF_MIN_ABS_SPEED,
  parameter int RELEASE_CYC   = DEF_RELEASE_CYC,
  parameter int APPLY_MIN_CYC = DEF_APPLY_MIN_CYC
) (
  input logic                 clk,
  input logic                 rst,
  abs_multi_channel_if.slave  bus
);

  logic [SPD_W-1:0]    ref_speed;
  logic [N_WHEELS-1:0] slip;
  logic [N_WHEELS-1:0] brake_cmd;
  logic [N_WHEELS-1:0] releasing;

  always_comb begin
    ref_speed = '0;
    for (int i = 0; i < N_WHEELS; i++) begin
      ref_speed = SPD_W'(max_u(32'(ref_speed),
                               32'(bus.wheel_speed[i*SPD_W +: SPD_W])));
    end
  end

  // Modulation is only meaningful above a minimum vehicle speed.
  logic fast_enough;
  assign fast_enough = 32'(ref_speed) >= 32'(MIN_ABS_SPEED);

  for (genvar i = 0; i < N_WHEELS; i++) begin : g_wheel
    // ref_speed is the maximum, so this difference never underflows.
    logic [SPD_W-1:0] lag;
    assign lag     = ref_speed - bus.wheel_speed[i*SPD_W +: SPD_W];
    assign slip[i] = (32'(lag) > 32'(SLIP_MARGIN)) && fast_enough && bus.abs_enable;

    abs_wheel_channel #(
      .RELEASE_CYC   (RELEASE_CYC),
      .APPLY_MIN_CYC (APPLY_MIN_CYC)
    ) u_channel (
      .clk             (clk),
      .rst             (rst),
      .brake_pedal     (bus.brake_pedal),
      .object_detected (bus.object_detected),
      .slip            (slip[i]),
      .brake_cmd       (brake_cmd[i]),
      .releasing       (releasing[i])
    );
  end

  assign bus.brake_cmd  = brake_cmd;
  assign bus.abs_active = |releasing;
  assign bus.ref_speed  = ref_speed;

endmodule

// File: tb/tb_abs_multi_channel.sv
// Self-checking bench for abs_multi_channel: a table of hand-derived vectors,
// hand-written corner sequences, and a randomized run against a behavioural
// model that tracks remaining release/dwell cycles per wheel.
module tb_abs_multi_channel;
  import abs_pkg::*;

  localparam int NW     = 4;
  localparam int SW     = 8;
  localparam int MARGIN = 10;
  localparam int MINSPD = 15;
  localparam int REL    = 4;
  localparam int APP    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  abs_multi_channel_if #(.N_WHEELS(NW), .SPD_W(SW)) bus ();

  abs_multi_channel #(
    .N_WHEELS      (NW),
    .SPD_W         (SW),
    .SLIP_MARGIN   (MARGIN),
    .MIN_ABS_SPEED (MINSPD),
    .RELEASE_CYC   (REL),
    .APPLY_MIN_CYC (APP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_lock [NW];
  bit m_on   [NW];   // pedal-driven braking engaged
  int m_rel  [NW];   // release cycles still to run (0 = not releasing)
  int m_dwell[NW];   // apply cycles still required before slip may act

  function automatic int spd(input int i);
    return int'(bus.wheel_speed[i*SW +: SW]);
  endfunction

  function automatic int model_ref();
    int r = 0;
    for (int j = 0; j < NW; j++) if (spd(j) > r) r = spd(j);
    return r;
  endfunction

  function automatic bit model_slip(input int i);
    int r = model_ref();
    return ((r - spd(i)) > MARGIN) && (r >= MINSPD) && bus.abs_enable;
  endfunction

  task automatic model_clear(input int i);
    m_lock[i] = 0; m_on[i] = 0; m_rel[i] = 0; m_dwell[i] = 0;
  endtask

  task automatic model_step();
    bit sl[NW];
    for (int i = 0; i < NW; i++) sl[i] = model_slip(i);
    for (int i = 0; i < NW; i++) begin
      if (rst) model_clear(i);
      else if (bus.object_detected) begin
        model_clear(i);
        m_lock[i] = 1;
      end else if (!bus.brake_pedal) model_clear(i);
      else if (m_lock[i] || !m_on[i]) begin
        model_clear(i);
        m_on[i] = 1;
      end else if (m_rel[i] > 0) begin
        m_rel[i]--;
        if (m_rel[i] == 0) m_dwell[i] = APP;
      end else if (m_dwell[i] > 1) m_dwell[i]--;
      else if (sl[i]) begin
        m_rel[i]   = REL;
        m_dwell[i] = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [NW-1:0] eb;
    logic          ea;
    eb = '0;
    ea = 1'b0;
    for (int i = 0; i < NW; i++) begin
      eb[i] = m_lock[i] || (m_on[i] && m_rel[i] == 0);
      if (m_rel[i] > 0) ea = 1'b1;
    end
    check({tag, "_brake"},  32'(bus.brake_cmd),  32'(eb));
    check({tag, "_active"}, 32'(bus.abs_active), 32'(ea));
    check({tag, "_ref"},    32'(bus.ref_speed),  32'(model_ref()));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic p, input logic o, input logic e,
                       input logic [NW*SW-1:0] s);
    bus.brake_pedal     = p;
    bus.object_detected = o;
    bus.abs_enable      = e;
    bus.wheel_speed     = s;
  endtask

  // One clock: model advances at the edge, outputs are sampled at the negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [NW-1:0] b, input logic a);
    check({name, "_brake"},  32'(bus.brake_cmd),  32'(b));
    check({name, "_active"}, 32'(bus.abs_active), 32'(a));
  endtask

  typedef struct {
    logic          pedal;
    logic          obj;
    logic          en;
    logic [NW*SW-1:0] spd;
    logic [NW-1:0] exp_brake;
    logic          exp_active;
    logic [SW-1:0] exp_ref;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic p, input logic o, input logic e, input logic [NW*SW-1:0] s,
                     input logic [NW-1:0] b, input logic a, input logic [SW-1:0] r);
    vec_t v;
    v.pedal = p; v.obj = o; v.en = e; v.spd = s;
    v.exp_brake = b; v.exp_active = a; v.exp_ref = r;
    tbl.push_back(v);
  endtask

  localparam logic [NW*SW-1:0] SLIP_SPD = {8'd40, 8'd60, 8'd60, 8'd60};
  localparam logic [NW*SW-1:0] LOW_SPD  = {8'd0, 8'd12, 8'd12, 8'd12};

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, SLIP_SPD);
    for (int i = 0; i < NW; i++) model_clear(i);

    // Reset holds outputs low even with the pedal pressed; ref_speed is live.
    cycle();
    cycle();
    expect_out("reset", 4'b0000, 1'b0);
    check("reset_ref", 32'(bus.ref_speed), 32'd60);
    rst = 1'b0;
    cycle();
    expect_out("reset_exit", 4'b1111, 1'b0);

    // Single-wheel slip on wheel 3: 4 released cycles, 6 applied, repeat.
    add(1'b0, 1'b0, 1'b1, SLIP_SPD, 4'b0000, 1'b0, 8'd60);
    add(1'b1, 1'b0, 1'b1, SLIP_SPD, 4'b1111, 1'b0, 8'd60);
    for (int k = 0; k < REL; k++) add(1'b1, 1'b0, 1'b1, SLIP_SPD, 4'b0111, 1'b1, 8'd60);
    for (int k = 0; k < APP; k++) add(1'b1, 1'b0, 1'b1, SLIP_SPD, 4'b1111, 1'b0, 8'd60);
    for (int k = 0; k < REL; k++) add(1'b1, 1'b0, 1'b1, SLIP_SPD, 4'b0111, 1'b1, 8'd60);
    add(1'b1, 1'b0, 1'b1, SLIP_SPD, 4'b1111, 1'b0, 8'd60);
    add(1'b0, 1'b0, 1'b1, SLIP_SPD, 4'b0000, 1'b0, 8'd60);
    add(1'b0, 1'b0, 1'b1, {8'd10, 8'd200, 8'd3, 8'd99}, 4'b0000, 1'b0, 8'd200);
    add(1'b0, 1'b0, 1'b1, {8'd255, 8'd0, 8'd254, 8'd1}, 4'b0000, 1'b0, 8'd255);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].pedal, tbl[k].obj, tbl[k].en, tbl[k].spd);
      cycle();
      expect_out($sformatf("tbl%0d", k), tbl[k].exp_brake, tbl[k].exp_active);
      check($sformatf("tbl%0d_ref", k), 32'(bus.ref_speed), 32'(tbl[k].exp_ref));
    end

    // Low reference speed suppresses modulation.
    drive(1'b0, 1'b0, 1'b1, LOW_SPD);
    do_reset();
    drive(1'b1, 1'b0, 1'b1, LOW_SPD);
    for (int k = 0; k < 12; k++) begin
      cycle();
      expect_out($sformatf("lowspd%0d", k), 4'b1111, 1'b0);
    end

    // ABS disabled: no release despite heavy slip.
    drive(1'b0, 1'b0, 1'b0, SLIP_SPD);
    do_reset();
    drive(1'b1, 1'b0, 1'b0, SLIP_SPD);
    for (int k = 0; k < 12; k++) begin
      cycle();
      expect_out($sformatf("absdis%0d", k), 4'b1111, 1'b0);
    end

    // Obstacle during the second release cycle, then lock exits.
    drive(1'b0, 1'b0, 1'b1, SLIP_SPD);
    do_reset();
    drive(1'b1, 1'b0, 1'b1, SLIP_SPD);
    cycle();
    expect_out("obs_apply", 4'b1111, 1'b0);
    cycle();
    expect_out("obs_rel1", 4'b0111, 1'b1);
    cycle();
    expect_out("obs_rel2", 4'b0111, 1'b1);
    drive(1'b1, 1'b1, 1'b1, SLIP_SPD);
    for (int k = 0; k < 4; k++) begin
      cycle();
      expect_out($sformatf("obs_lock%0d", k), 4'b1111, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b1, SLIP_SPD);
    cycle();
    expect_out("lockexit_pedal", 4'b1111, 1'b0);
    drive(1'b0, 1'b0, 1'b1, SLIP_SPD);
    cycle();
    expect_out("apply_to_idle", 4'b0000, 1'b0);
    drive(1'b0, 1'b1, 1'b1, SLIP_SPD);
    cycle();
    expect_out("idle_to_lock", 4'b1111, 1'b0);
    drive(1'b0, 1'b0, 1'b1, SLIP_SPD);
    cycle();
    expect_out("lockexit_nopedal", 4'b0000, 1'b0);

    // Pedal and obstacle together from IDLE: LOCK wins (no release follows).
    cycle();
    drive(1'b1, 1'b1, 1'b1, SLIP_SPD);
    cycle();
    expect_out("both_rise0", 4'b1111, 1'b0);
    cycle();
    expect_out("both_rise1", 4'b1111, 1'b0);
    drive(1'b1, 1'b0, 1'b1, SLIP_SPD);
    cycle();
    expect_out("lock_to_apply", 4'b1111, 1'b0);
    cycle();
    expect_out("first_apply_nodwell", 4'b0111, 1'b1);

    // Reset mid-pulse: outputs drop immediately, no timer state survives.
    drive(1'b0, 1'b0, 1'b1, SLIP_SPD);
    do_reset();
    drive(1'b1, 1'b0, 1'b1, SLIP_SPD);
    cycle();
    cycle();
    cycle();
    expect_out("midpulse_rel", 4'b0111, 1'b1);
    rst = 1'b1;
    #1;
    expect_out("midpulse_async", 4'b0000, 1'b0);
    cycle();
    expect_out("midpulse_held", 4'b0000, 1'b0);
    rst = 1'b0;
    cycle();
    expect_out("midpulse_reapply", 4'b1111, 1'b0);
    cycle();
    expect_out("midpulse_norm", 4'b0111, 1'b1);

    // Randomized run against the model.
    begin
      logic [NW*SW-1:0] s;
      logic p, o, e;
      s = '0;
      p = 1'b1; o = 1'b0; e = 1'b1;
      for (int k = 0; k < 3000; k++) begin
        if (k % 8 == 0) begin
          int base;
          base = int'($urandom_range(0, 255));
          for (int i = 0; i < NW; i++) begin
            int d;
            int w;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
            w = (base >= d) ? base - d : 0;
            s[i*SW +: SW] = SW'(w);
          end
          p = ($urandom_range(0, 15) != 0);
          e = ($urandom_range(0, 9) != 0);
        end
        if ($urandom_range(0, 49) == 0) o = ~o;
        rst = ($urandom_range(0, 499) == 0);
        drive(p, o, e, s);
        cycle();
        check_model($sformatf("rand%0d", k));
      end
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
